// File: rtl/dram_port_arbiter.sv
// Two-master arbiter for the single-port data RAM.
// Port 0 (CPU data side) has fixed priority; port 1 (debug/display reader)
// is guaranteed a slot after MAX_WAIT consecutive blocked cycles.
// One access is accepted per cycle; read data returns two cycles after the
// grant, in accept order, with a per-port valid strobe.
module dram_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // port 0: CPU data side
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    // port 1: debug / display reader
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    // RAM side
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    // Saturation point of the starvation counter, sized to the counter.
    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [3:0]        wait_q, wait_d;
    logic              force1;

    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_din_q;

    // Read tag pipeline: A tracks the access presented to the RAM, B tracks
    // the cycle in which the RAM returns its data.
    logic              tag_a_valid_q, tag_a_port_q;
    logic              tag_b_valid_q, tag_b_port_q;

    logic [1:0]        rvalid_vec;

    // Grant decision: port 0 wins unless port 1 has waited MAX_WAIT cycles.
    // Nothing is granted while reset is asserted so no access leaks through.
    always_comb begin
        force1 = req1 && (wait_q == MAX_CNT);
        gnt1   = !rst && req1 && (!req0 || force1);
        gnt0   = !rst && req0 && !force1;
    end

    // Starvation counter next state: clears whenever port 1 is idle or served.
    always_comb begin
        wait_d = wait_q;
        if (!req1 || gnt1) begin
            wait_d = 4'd0;
        end else if (wait_q < MAX_CNT) begin
            wait_d = wait_q + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= 4'd0;
        end else begin
            wait_q <= wait_d;
        end
    end

    // Issue stage: register the winning request onto the RAM bus.
    // Address and data hold when idle; only the write enable is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else if (gnt0) begin
            ram_we_q   <= we0;
            ram_addr_q <= addr0;
            ram_din_q  <= wdata0;
        end else if (gnt1) begin
            ram_we_q   <= we1;
            ram_addr_q <= addr1;
            ram_din_q  <= wdata1;
        end else begin
            ram_we_q   <= 1'b0;
        end
    end

    // Read tag pipeline: remember which port owns each in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_a_valid_q <= 1'b0;
            tag_a_port_q  <= 1'b0;
            tag_b_valid_q <= 1'b0;
            tag_b_port_q  <= 1'b0;
        end else begin
            tag_a_valid_q <= (gnt0 && !we0) || (gnt1 && !we1);
            tag_a_port_q  <= !gnt0 && gnt1;
            tag_b_valid_q <= tag_a_valid_q;
            tag_b_port_q  <= tag_a_port_q;
        end
    end

    // Per-port read valid decode; masked during reset so a dropped read
    // never produces a strobe.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rvalid
            assign rvalid_vec[gi] = !rst && tag_b_valid_q && (tag_b_port_q == 1'(gi));
        end
    endgenerate

    assign rvalid0  = rvalid_vec[0];
    assign rvalid1  = rvalid_vec[1];
    assign rdata0   = ram_dout;
    assign rdata1   = ram_dout;

    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Testbench for dram_port_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_dram_port_arbiter;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, we0, req1, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    dram_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .we0     (we0),
        .addr0   (addr0),
        .wdata0  (wdata0),
        .gnt0    (gnt0),
        .rvalid0 (rvalid0),
        .rdata0  (rdata0),
        .req1    (req1),
        .we1     (we1),
        .addr1   (addr1),
        .wdata1  (wdata1),
        .gnt1    (gnt1),
        .rvalid1 (rvalid1),
        .rdata1  (rdata1),
        .ram_we  (ram_we),
        .ram_addr(ram_addr),
        .ram_din (ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Bench-side RAM with one-cycle registered read.
    logic [DATA_W-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        bit          port;
        logic [31:0] data;
    } rd_t;

    logic [DATA_W-1:0] m_mem [DEPTH];
    rd_t               m_rdq[$];
    int                m_blocked;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_din;
    int                cyc;
    bit                g0_last, g1_last;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock cycle: apply inputs, check outputs at the falling edge,
    // then advance the model by one accept.
    task automatic do_cycle(input bit r,
                            input bit q0, input bit w0, input int a0, input logic [31:0] d0,
                            input bit q1, input bit w1, input int a1, input logic [31:0] d1);
        bit          e0, e1, f1, ev0, ev1;
        logic [31:0] ed;
        rst = r;
        req0 = q0; we0 = w0; addr0 = ADDR_W'(a0); wdata0 = d0;
        req1 = q1; we1 = w1; addr1 = ADDR_W'(a1); wdata1 = d1;
        @(negedge clk);
        e0 = 0; e1 = 0;
        if (!r) begin
            f1 = q1 && (m_blocked >= MAX_WAIT);
            e1 = q1 && (!q0 || f1);
            e0 = q0 && !f1;
        end
        ev0 = 0; ev1 = 0; ed = '0;
        if (m_rdq.size() > 0 && m_rdq[0].due == cyc) begin
            rd_t t;
            t = m_rdq.pop_front();
            if (!r) begin
                ev0 = (t.port == 1'b0);
                ev1 = (t.port == 1'b1);
                ed  = t.data;
            end
        end
        check_eq("gnt0", 32'(gnt0), 32'(e0));
        check_eq("gnt1", 32'(gnt1), 32'(e1));
        check_eq("rvalid0", 32'(rvalid0), 32'(ev0));
        check_eq("rvalid1", 32'(rvalid1), 32'(ev1));
        if (ev0) check_eq("rdata0", rdata0, ed);
        if (ev1) check_eq("rdata1", rdata1, ed);
        check_eq("ram_we", 32'(ram_we), 32'(exp_we));
        check_eq("ram_addr", 32'(ram_addr), 32'(exp_addr));
        check_eq("ram_din", ram_din, exp_din);
        $display("cyc %0d rst=%0d req=%0d%0d gnt=%0d%0d rv=%0d%0d we=%0d addr=%03h",
                 cyc, r, q0, q1, gnt0, gnt1, rvalid0, rvalid1, ram_we, ram_addr);
        if (r) begin
            m_rdq.delete();
            m_blocked = 0;
            exp_we = 0; exp_addr = '0; exp_din = '0;
        end else begin
            if (e0 || e1) begin
                bit          w;
                int          a;
                logic [31:0] d;
                w = e0 ? w0 : w1;
                a = e0 ? a0 : a1;
                d = e0 ? d0 : d1;
                exp_we = w; exp_addr = ADDR_W'(a); exp_din = d;
                if (w) m_mem[a] = d;
                else   m_rdq.push_back('{cyc + 2, e1, m_mem[a]});
            end else begin
                exp_we = 0;
            end
            m_blocked = (q1 && !e1) ? m_blocked + 1 : 0;
        end
        g0_last = e0; g1_last = e1;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          p0_req, p0_we, p1_req, p1_we, rr;
        int          p0_a, p1_a;
        logic [31:0] p0_d, p1_d;

        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] v;
            v = $urandom;
            m_mem[i] = v;
            ram_mem[i] = v;
        end
        m_mem[5] = 32'hDEADBEEF; ram_mem[5] = 32'hDEADBEEF;
        m_mem[1] = 32'h11111111; ram_mem[1] = 32'h11111111;
        m_mem[2] = 32'h22222222; ram_mem[2] = 32'h22222222;

        cyc = 0;
        rst = 1; req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        m_blocked = 0; exp_we = 0; exp_addr = '0; exp_din = '0;
        g0_last = 0; g1_last = 0;

        // reset state, then port 0 read of 0x005
        idle(1);
        do_cycle(0, 1, 0, 5, 0, 0, 0, 0, 0);
        idle(3);

        // both ports requesting continuously: 4 x port0 then 1 x port1
        for (int i = 0; i < 12; i++) do_cycle(0, 1, 0, 32 + i, 0, 1, 0, 64 + i, 0);
        idle(3);

        // write then read of the same word on back-to-back accepts
        do_cycle(0, 1, 1, 16, 32'h12345678, 0, 0, 0, 0);
        do_cycle(0, 1, 0, 16, 0, 0, 0, 0, 0);
        idle(3);

        // interleaved reads across ports
        do_cycle(0, 1, 0, 1, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 1, 0, 2, 0);
        idle(3);

        // reset while a read is in flight
        do_cycle(0, 1, 0, 7, 0, 0, 0, 0, 0);
        do_cycle(1, 1, 1, 9, 32'hCAFEF00D, 1, 0, 3, 0);
        idle(4);

        // port 1 alone for ten cycles
        for (int i = 0; i < 10; i++) do_cycle(0, 0, 0, 0, 0, 1, 0, (i % 2) ? 3 : 4, 0);
        idle(3);

        // random traffic; an ungranted request is held unchanged
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
        p0_a = 0; p1_a = 0; p0_d = 0; p1_d = 0;
        for (int n = 0; n < 400; n++) begin
            rr = ($urandom_range(0, 99) < 2);
            if (!p0_req || g0_last) begin
                p0_req = ($urandom_range(0, 99) < 70);
                p0_we  = $urandom_range(0, 1) == 1;
                p0_a   = $urandom_range(0, 15);
                p0_d   = $urandom;
            end
            if (!p1_req || g1_last) begin
                p1_req = ($urandom_range(0, 99) < 60);
                p1_we  = $urandom_range(0, 3) == 0;
                p1_a   = $urandom_range(0, 15);
                p1_d   = $urandom;
            end
            do_cycle(rr, p0_req, p0_we, p0_a, p0_d, p1_req, p1_we, p1_a, p1_d);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
